// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared owner type, default sizes and saturating increment for the dmem arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LD   = 2'd2
  } owner_t;

  localparam int DEF_N         = 32;
  localparam int DEF_A         = 32;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_CW        = 16;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rtl/dmem_arbiter_rr_pick2.sv - two-way round-robin picker, one-hot grant (bit0 = CPU, bit1 = loader)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // last=1 means requester 1 owned the most recent grant, so requester 0 wins a tie.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares dmem between the CPU data port and the loader port
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int N         = DEF_N,
  parameter int A         = DEF_A,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [A-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [N-1:0]  cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_lock,
  input  logic          ld_we,
  input  logic [A-1:0]  ld_addr,
  input  logic [N-1:0]  ld_wdata,
  output logic          ld_gnt,
  output logic [N-1:0]  ld_rdata,
  output logic          mem_we,
  output logic [A-1:0]  mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  output logic [CW-1:0] stall_cnt
);

  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);

  owner_t        r_last_owner;
  logic [BW-1:0] r_beat_cnt;
  logic [CW-1:0] r_stall_cnt;

  owner_t        w_owner;
  logic          w_lock;
  logic [1:0]    w_pick;

  rr_pick2 u_pick (
    .req  ({ld_req, cpu_req}),
    .last (r_last_owner == OWN_LD),
    .gnt  (w_pick)
  );

  // A held lock yields once the burst limit is hit, but only if the CPU is actually waiting.
  assign w_lock = (r_beat_cnt != '0) && ld_req && ((r_beat_cnt < BEAT_MAX) || !cpu_req);

  always_comb begin
    w_owner = OWN_NONE;
    if (reset)          w_owner = OWN_NONE;
    else if (w_lock)    w_owner = OWN_LD;
    else if (w_pick[0]) w_owner = OWN_CPU;
    else if (w_pick[1]) w_owner = OWN_LD;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_owner)
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_LD: begin
        mem_we    = ld_we;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_gnt   = (w_owner == OWN_CPU);
  assign ld_gnt    = (w_owner == OWN_LD);
  assign cpu_stall = cpu_req && !cpu_gnt && !reset;
  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;
  assign ld_rdata  = ld_gnt ? mem_rdata : '0;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_owner <= OWN_LD;
      r_beat_cnt   <= '0;
      r_stall_cnt  <= '0;
    end else begin
      case (w_owner)
        OWN_LD: begin
          r_last_owner <= OWN_LD;
          r_beat_cnt   <= ld_lock ? BW'(sat_inc(32'(r_beat_cnt), 32'(MAX_BURST))) : '0;
        end
        OWN_CPU: begin
          r_last_owner <= OWN_CPU;
          r_beat_cnt   <= '0;
        end
        default: r_beat_cnt <= '0;
      endcase
      if (cpu_stall && (r_stall_cnt != {CW{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - vector table plus scoreboard bench for dmem_arbiter, with a word RAM model
module tb_dmem_arbiter;

  localparam int N  = 32;
  localparam int A  = 32;
  localparam int MB = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, ld_req, ld_lock, ld_we;
  logic [A-1:0]  cpu_addr, ld_addr;
  logic [N-1:0]  cpu_wdata, ld_wdata;
  logic          cpu_gnt, cpu_stall, ld_gnt, mem_we;
  logic [N-1:0]  cpu_rdata, ld_rdata, mem_wdata, mem_rdata;
  logic [A-1:0]  mem_addr;
  logic [CW-1:0] stall_cnt;

  logic [31:0] ram [0:255];
  logic        ram_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        lr, lk, lw;
    logic [31:0] la, ld;
    logic        cg, lg;
    logic [31:0] rc, rl;
    logic [3:0]  st;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.N(N), .A(A), .MAX_BURST(MB), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_lock(ld_lock), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt)
  );

  assign mem_rdata = ram[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'hA000_0000 + 32'(i);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic lr, input logic lk, input logic lw, input logic [31:0] la,
                     input logic [31:0] ld, input logic cg, input logic lg,
                     input logic [31:0] rc, input logic [31:0] rl, input logic [3:0] st);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.lr = lr; v.lk = lk; v.lw = lw; v.la = la; v.ld = ld;
    v.cg = cg; v.lg = lg; v.rc = rc; v.rl = rl; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    ld_req = v.lr; ld_lock = v.lk; ld_we = v.lw; ld_addr = v.la; ld_wdata = v.ld;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_lock = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
  endtask

  initial begin
    vec_t e;
    int   both;
    reset = 1'b1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h55;
    ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = 32'h20; ld_wdata = 32'h66;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_ld_gnt", 32'(ld_gnt), 0);
    chk("rst_cpu_stall", 32'(cpu_stall), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    idle();
    reset = 1'b0;

    // Tie after reset alternates, CPU first
    for (int i = 0; i < 4; i++)
      add(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, (i % 2) == 0, (i % 2) == 1,
          (i % 2) == 0 ? 32'hA000_0004 : 0, (i % 2) == 1 ? 32'hA000_0008 : 0, 4'(i / 2));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd2);
    add(1, 1, 32'd84, 32'h96, 0, 0, 0, 0, 0, 1, 0, 32'hA000_0015, 0, 4'd2);
    // Loader burst against a waiting CPU: 4 LD beats, one CPU cycle, then LD again
    for (int i = 0; i < 4; i++)
      add(1, 0, 32'h10, 0, 1, 1, 0, 32'h20, 0, 0, 1, 0, 32'hA000_0008, 4'(2 + i));
    add(1, 0, 32'h10, 0, 1, 1, 0, 32'h20, 0, 1, 0, 32'hA000_0004, 0, 4'd6);
    add(1, 0, 32'h10, 0, 1, 1, 0, 32'h20, 0, 0, 1, 0, 32'hA000_0008, 4'd6);
    add(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA000_0004, 0, 4'd7);
    for (int i = 0; i < 10; i++)
      add(0, 0, 0, 0, 1, 1, 0, 32'h20, 0, 0, 1, 0, 32'hA000_0008, 4'd7);
    add(0, 0, 0, 0, 1, 0, 1, 32'd8, 32'h1234, 0, 1, 0, 32'hA000_0002, 4'd7);
    add(1, 0, 32'd8, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 4'd7);

    @(posedge clk);
    foreach (tbl[k]) begin
      #1;
      drive(tbl[k]);
      sb.push_back(tbl[k]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_cpu_gnt", k), 32'(cpu_gnt), 32'(e.cg));
      chk($sformatf("v%0d_ld_gnt", k), 32'(ld_gnt), 32'(e.lg));
      chk($sformatf("v%0d_cpu_stall", k), 32'(cpu_stall), 32'(e.cr & ~e.cg));
      chk($sformatf("v%0d_mem_we", k), 32'(mem_we), e.cg ? 32'(e.cw) : e.lg ? 32'(e.lw) : 0);
      chk($sformatf("v%0d_mem_addr", k), mem_addr, e.cg ? e.ca : e.lg ? e.la : 0);
      chk($sformatf("v%0d_mem_wdata", k), mem_wdata, e.cg ? e.cd : e.lg ? e.ld : 0);
      chk($sformatf("v%0d_cpu_rdata", k), cpu_rdata, e.rc);
      chk($sformatf("v%0d_ld_rdata", k), ld_rdata, e.rl);
      chk($sformatf("v%0d_stall_cnt", k), 32'(stall_cnt), 32'(e.st));
      @(posedge clk);
    end
    #1;
    chk("ram_84", ram[21], 32'h96);
    chk("ram_8", ram[2], 32'h1234);

    // Saturation of stall_cnt under continuous loader bursts; grants never overlap
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    ld_req = 1; ld_lock = 1; ld_we = 0; ld_addr = 32'h20;
    both = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpu_gnt && ld_gnt) both++;
    end
    chk("grant_overlap", 32'(both), 0);
    chk("stall_sat", 32'(stall_cnt), 32'hF);

    // Reset in the middle of a locked loader write burst
    @(posedge clk); #1;
    cpu_req = 0; ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = 32'h40; ld_wdata = 32'h11;
    @(posedge clk); #1;
    ld_addr = 32'h44; ld_wdata = 32'hBEEF;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ld_gnt", 32'(ld_gnt), 0);
    chk("mid_rst_mem_we", 32'(mem_we), 0);
    chk("mid_rst_stall_cnt", 32'(stall_cnt), 0);
    @(posedge clk); #1;
    chk("mid_rst_beat1_write", ram[16], 32'h11);
    chk("mid_rst_no_write", ram[17], 32'hA000_0011);
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; ld_req = 1; ld_lock = 0; ld_we = 0;
    reset = 1'b0;
    #1;
    chk("post_rst_tie_cpu", 32'(cpu_gnt), 1);
    chk("post_rst_tie_ld", 32'(ld_gnt), 0);
    @(posedge clk); #1;
    chk("post_rst_tie2_ld", 32'(ld_gnt), 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory (dmem) between two requesters: the MIPS CPU data port and a program/debug loader port.
- Sits between the `computer` top level and dmem.
- Grants one access per cycle using round-robin arbitration, with a bounded loader burst lock.
- Stalls the CPU when it loses arbitration and counts CPU stall cycles for performance checks.

Parameters:
- N, 32, data width in bits
- A, 32, byte address width in bits
- MAX_BURST, 4, maximum consecutive locked loader beats while the CPU is waiting (≥1)
- CW, 16, stall counter width

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU requests a dmem access this cycle
- cpu_we  in  1  CPU access is a write
- cpu_addr  in  A  CPU address
- cpu_wdata  in  N  CPU write data
- cpu_gnt  out  1  CPU owns dmem this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rdata  out  N  mem_rdata when cpu_gnt, else 0
- ld_req  in  1  loader requests access
- ld_lock  in  1  loader asks to keep ownership next cycle
- ld_we  in  1  loader access is a write
- ld_addr  in  A  loader address
- ld_wdata  in  N  loader write data
- ld_gnt  out  1  loader owns dmem this cycle
- ld_rdata  out  N  mem_rdata when ld_gnt, else 0
- mem_we  out  1  dmem write enable
- mem_addr  out  A  dmem address
- mem_wdata  out  N  dmem write data
- mem_rdata  in  N  dmem combinational read data
- stall_cnt  out  CW  saturating count of cycles with cpu_stall=1

Behaviour:
- The interface uses one clock (clk) and an asynchronous, active-high reset (reset). These are fixed.
- State registers:
  - last_owner, values CPU or LD; reset value LD, so the CPU wins the first tie.
  - beat_cnt, range 0..MAX_BURST; reset value 0.
  - stall_cnt; reset value 0.
- Owner selection is combinational, same cycle, evaluated in this order:
  1. Lock: if beat_cnt>0 & ld_req & (beat_cnt<MAX_BURST | ~cpu_req), owner=LD.
  2. Tie: else if cpu_req & ld_req, owner = (last_owner==CPU) ? LD : CPU.
  3. Single requester: else if cpu_req, owner=CPU; else if ld_req, owner=LD.
  4. Otherwise owner=NONE.
- Outputs by owner:
  - cpu_gnt = (owner==CPU); ld_gnt = (owner==LD). They are never both 1.
  - The owner's addr, wdata and we drive mem_*.
  - When owner=NONE: mem_addr=0, mem_wdata=0, mem_we=0.
  - mem_we is never 1 without a grant.
- Reads are zero latency: rdata is valid in the grant cycle. A write commits at the rising edge that ends the grant cycle.
- State updates at each rising edge:
  - owner=LD: last_owner←LD. beat_cnt←ld_lock ? min(beat_cnt+1, MAX_BURST) : 0.
  - owner=CPU: last_owner←CPU, beat_cnt←0.
  - owner=NONE: beat_cnt←0; last_owner holds.
  - stall_cnt increments when cpu_stall=1 and saturates at 2^CW−1.
- Lock boundary: when beat_cnt==MAX_BURST and cpu_req=1, the lock is ignored. Because last_owner==LD, the CPU gets exactly one cycle; the loader may then re-acquire the lock.
- Lock release: dropping ld_req or ld_lock ends the lock on the next edge (beat_cnt←0).
- Reset during a burst, or during any operation: all grants, mem_we and stall_cnt go to 0 immediately (asynchronous). last_owner←LD and beat_cnt←0. No write commits at that edge.
- During reset, cpu_gnt, ld_gnt, cpu_stall and mem_we are forced to 0 regardless of the req inputs.
- Requesters must hold addr, we and wdata stable while req=1 and gnt=0.

Decomposition:
- Package dmem_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_LD};
  - default N, A, MAX_BURST, CW constants;
  - helper function sat_inc.
- One natural sub-module, rr_pick2: a two-way round-robin picker taking req[1:0] and last, producing a one-hot grant. Lock override and counters stay in dmem_arbiter.

Test Plan:
- CPU alone: cpu_req=1, cpu_we=1, cpu_addr=84, cpu_wdata=0x96 for 1 cycle → cpu_gnt=1, mem_we=1, RAM[84]=0x96 after the edge, cpu_stall=0, stall_cnt=0.
- Tie after reset: cpu_req=ld_req=1, ld_lock=0, for 4 cycles → grants alternate CPU, LD, CPU, LD; stall_cnt=2.
- Loader burst: ld_req=ld_lock=1 with cpu_req=1 throughout, MAX_BURST=4, loader wins the first tie (last_owner=CPU) → ld_gnt for 4 cycles, then 1 CPU cycle, then LD again.
- Lock with idle CPU: ld_req=ld_lock=1, cpu_req=0, for 10 cycles → ld_gnt=1 every cycle; beat_cnt saturates at 4.
- Read path: ld writes 0x1234 at address 8; next cycle the CPU reads address 8 → cpu_rdata=0x1234 in the grant cycle, ld_rdata=0.
- Reset mid-burst: assert reset at beat 2 of a locked loader write → ld_gnt and mem_we drop to 0 immediately, no write at that edge; after release, a tie grants the CPU first.
